// File: rtl/aes_mm_pkg.sv
// rtl/aes_mm_pkg.sv - shared constants, state type and helpers for the AES bus master
//
// Purpose: register map of the AES slave, master FSM states, block word select.
// Ports:   none (package).
package aes_mm_pkg;

  localparam logic [3:0] ADDR_DATA0     = 4'd0;
  localparam logic [3:0] ADDR_DATA1     = 4'd1;
  localparam logic [3:0] ADDR_DATA2     = 4'd2;
  localparam logic [3:0] ADDR_DATA3     = 4'd3;
  localparam logic [3:0] ADDR_LOAD_DATA = 4'd4;
  localparam logic [3:0] ADDR_LOAD_KEY  = 4'd5;
  localparam logic [3:0] ADDR_RES0      = 4'd6;
  localparam logic [3:0] ADDR_RES1      = 4'd7;
  localparam logic [3:0] ADDR_RES2      = 4'd8;
  localparam logic [3:0] ADDR_RES3      = 4'd9;
  localparam logic [3:0] ADDR_VALID     = 4'd10;
  localparam logic [3:0] ADDR_READY     = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RDY_RD,
    ST_RDY_CHK,
    ST_WR,
    ST_LOAD,
    ST_GAP,
    ST_VAL_RD,
    ST_VAL_CHK,
    ST_RES_RD,
    ST_RES_CAP,
    ST_FIN
  } state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_mm_master_if.sv
// rtl/aes_mm_master_if.sv - chip-select/strobe bus between the AES master and slave
//
// Purpose: groups the 32-bit register bus.
// Signals: oChipSelect_n, oWrite_n, oRead_n (active low), oAddress[3:0], oData[31:0]
//          driven by the master; iData[31:0] driven by the slave.
interface aes_mm_master_if;

  logic        oChipSelect_n;
  logic        oWrite_n;
  logic        oRead_n;
  logic [3:0]  oAddress;
  logic [31:0] oData;
  logic [31:0] iData;

  modport master (
    output oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
    input  iData
  );

  modport slave (
    input  oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
    output iData
  );

endinterface

// File: rtl/aes_mm_bus_if.sv
// rtl/aes_mm_bus_if.sv - registered single-cycle register-bus access engine
//
// Purpose: turns a one-cycle req/we/addr/wdata request into a registered
//          one-cycle bus access (CS plus exactly one strobe low).
// Ports:   iClk, iReset_n (sync, active low); req, we, addr, wdata (request);
//          rdata_valid/rdata (read data, one cycle after the read strobe);
//          done (write strobe cycle or read data cycle); bus (master modport).
module aes_mm_bus_if (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        done,
  aes_mm_master_if.master bus
);

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      bus.oChipSelect_n <= 1'b1;
      bus.oWrite_n      <= 1'b1;
      bus.oRead_n       <= 1'b1;
      bus.oAddress      <= 4'd0;
      bus.oData         <= 32'd0;
      rdata_valid       <= 1'b0;
    end else begin
      bus.oChipSelect_n <= !req;
      bus.oWrite_n      <= !(req && we);
      bus.oRead_n       <= !(req && !we);
      if (req) begin
        bus.oAddress <= addr;
        bus.oData    <= we ? wdata : 32'd0;
      end
      // Slave returns data in the cycle after the strobe.
      rdata_valid <= !bus.oRead_n;
    end
  end

  assign rdata = bus.iData;
  assign done  = !bus.oWrite_n || rdata_valid;

endmodule

// File: rtl/aes_mm_master.sv
// rtl/aes_mm_master.sv - AES register-bus master: key load / encrypt command sequencer
//
// Purpose: executes one 128-bit key-load or encrypt command as a sequence of
//          ready poll, four data writes, load strobe and (encrypt) valid poll
//          plus four result reads.
// Ports:   iClk, iReset_n (sync, active low); iStart, iIsKey, iBlock (command);
//          oBusy, oDone, oError, oResult (status/result); bus (master modport).
module aes_mm_master
  import aes_mm_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024,
  parameter int LOAD_GAP     = 2
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iStart,
  input  logic         iIsKey,
  input  logic [127:0] iBlock,
  output logic         oBusy,
  output logic         oDone,
  output logic         oError,
  output logic [127:0] oResult,
  aes_mm_master_if.master bus
);

  localparam int CW = $clog2(POLL_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [127:0]   blk_q;
  logic [127:0]   shadow_q;
  logic           key_q;
  logic           err_q;
  logic           pend_q;
  logic [CW-1:0]  poll_q;
  logic [1:0]     idx_q;
  logic [7:0]     gap_q;

  logic           req;
  logic           we;
  logic [3:0]     addr;
  logic [31:0]    wdata;
  logic           rdata_valid;
  logic [31:0]    rdata;
  logic           acc_done;
  logic           poll_last;

  assign poll_last = (poll_q == CW'(POLL_TIMEOUT - 1));
  assign oError    = err_q;

  aes_mm_bus_if u_bus (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .done        (acc_done),
    .bus         (bus)
  );

  always_ff @(posedge iClk) begin
    if (!iReset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (iStart) state_d = ST_RDY_RD;
      ST_RDY_RD:  state_d = ST_RDY_CHK;
      ST_RDY_CHK: if (rdata_valid) begin
                    if (rdata[0])       state_d = ST_WR;
                    else if (poll_last) state_d = ST_FIN;
                    else                state_d = ST_RDY_RD;
                  end
      ST_WR:      if (acc_done && idx_q == 2'd3) state_d = ST_LOAD;
      ST_LOAD:    if (acc_done) state_d = key_q ? ST_FIN : ST_GAP;
      ST_GAP:     if (gap_q == 8'(LOAD_GAP - 1)) state_d = ST_VAL_RD;
      ST_VAL_RD:  state_d = ST_VAL_CHK;
      ST_VAL_CHK: if (rdata_valid) begin
                    if (rdata[0])       state_d = ST_RES_RD;
                    else if (poll_last) state_d = ST_FIN;
                    else                state_d = ST_VAL_RD;
                  end
      ST_RES_RD:  state_d = ST_RES_CAP;
      ST_RES_CAP: if (rdata_valid) state_d = (idx_q == 2'd3) ? ST_FIN : ST_RES_RD;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Writes wait on pend_q so each write is followed by an idle bus cycle.
  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    addr  = ADDR_DATA0;
    wdata = 32'd0;
    oBusy = 1'b1;
    oDone = 1'b0;
    case (state_q)
      ST_IDLE:   oBusy = 1'b0;
      ST_RDY_RD: begin
        req  = 1'b1;
        addr = ADDR_READY;
      end
      ST_WR: begin
        req   = !pend_q;
        we    = 1'b1;
        addr  = {2'b00, idx_q};
        wdata = block_word(blk_q, idx_q);
      end
      ST_LOAD: begin
        req  = !pend_q;
        we   = 1'b1;
        addr = key_q ? ADDR_LOAD_KEY : ADDR_LOAD_DATA;
      end
      ST_VAL_RD: begin
        req  = 1'b1;
        addr = ADDR_VALID;
      end
      ST_RES_RD: begin
        req  = 1'b1;
        addr = ADDR_RES0 + {2'b00, idx_q};
      end
      ST_FIN: begin
        oBusy = 1'b0;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      blk_q    <= '0;
      shadow_q <= '0;
      key_q    <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      poll_q   <= '0;
      idx_q    <= 2'd0;
      gap_q    <= 8'd0;
      oResult  <= '0;
    end else begin
      if (req)           pend_q <= 1'b1;
      else if (acc_done) pend_q <= 1'b0;

      case (state_q)
        ST_IDLE: if (iStart) begin
          blk_q  <= iBlock;
          key_q  <= iIsKey;
          err_q  <= 1'b0;
          poll_q <= '0;
        end
        ST_RDY_CHK, ST_VAL_CHK: if (rdata_valid) begin
          if (rdata[0]) begin
            idx_q <= 2'd0;
          end else begin
            poll_q <= poll_q + 1'b1;
            if (poll_last) err_q <= 1'b1;
          end
        end
        ST_WR: if (acc_done) idx_q <= idx_q + 2'd1;
        ST_LOAD: if (acc_done) begin
          poll_q <= '0;
          gap_q  <= 8'd0;
        end
        ST_GAP: gap_q <= gap_q + 8'd1;
        ST_RES_CAP: if (rdata_valid) begin
          case (idx_q)
            2'd0:    shadow_q[127:96] <= rdata;
            2'd1:    shadow_q[95:64]  <= rdata;
            2'd2:    shadow_q[63:32]  <= rdata;
            default: shadow_q[31:0]   <= rdata;
          endcase
          idx_q <= idx_q + 2'd1;
          // Last word goes straight in so oResult updates on entry to FIN.
          if (idx_q == 2'd3) oResult <= {shadow_q[127:32], rdata};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mm_master.sv
// tb/tb_aes_mm_master.sv - self-checking bench for aes_mm_master with a behavioural AES slave
module tb_aes_mm_master;

  localparam int PT = 8;
  localparam int LG = 2;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         is_key = 1'b0;
  logic [127:0] blk = '0;
  logic         busy, done, err;
  logic [127:0] res;

  aes_mm_master_if bus();

  aes_mm_master #(.POLL_TIMEOUT(PT), .LOAD_GAP(LG)) dut (
    .iClk     (clk),
    .iReset_n (rstn),
    .iStart   (start),
    .iIsKey   (is_key),
    .iBlock   (blk),
    .oBusy    (busy),
    .oDone    (done),
    .oError   (err),
    .oResult  (res),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t log_q[$];
  acc_t exp_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus log and per-cycle protocol checks.
  logic prev_cs_low = 1'b0;
  acc_t a_log;
  always @(negedge clk) begin
    if (rstn) begin
      if (!bus.oChipSelect_n) begin
        check("one_strobe", {127'd0, bus.oWrite_n ^ bus.oRead_n}, 128'd1);
        check("cs_gap", {127'd0, prev_cs_low}, 128'd0);
        a_log.we   = !bus.oWrite_n;
        a_log.addr = bus.oAddress;
        a_log.data = bus.oData;
        a_log.cyc  = cyc;
        log_q.push_back(a_log);
      end else begin
        check("idle_strobes", {126'd0, bus.oWrite_n, bus.oRead_n}, 128'd3);
      end
    end
    prev_cs_low <= rstn && !bus.oChipSelect_n;
  end

  function automatic logic [127:0] tb_cipher(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // Behavioural slave: answers ready/valid as 0 for rz/vz polls, then 1.
  logic [31:0]  s_data [4];
  logic [127:0] s_key = '0;
  logic [127:0] s_res = '0;
  int rdy_total = 0, val_total = 0;
  int rdy_base = 0, val_base = 0, rz = 0, vz = 0;
  logic rdy_ok, val_ok;
  assign rdy_ok = (rdy_total - rdy_base) >= rz;
  assign val_ok = (val_total - val_base) >= vz;

  always @(posedge clk) begin
    if (!bus.oChipSelect_n && !bus.oWrite_n) begin
      if (bus.oAddress < 4'd4) s_data[bus.oAddress[1:0]] <= bus.oData;
      else if (bus.oAddress == 4'd5) s_key <= {s_data[0], s_data[1], s_data[2], s_data[3]};
      else if (bus.oAddress == 4'd4) s_res <= tb_cipher(s_key, {s_data[0], s_data[1], s_data[2], s_data[3]});
    end
    if (!bus.oChipSelect_n && !bus.oRead_n) begin
      case (bus.oAddress)
        4'd15: begin
          bus.iData <= ($urandom() & 32'hffff_fffe) | {31'd0, rdy_ok};
          rdy_total <= rdy_total + 1;
        end
        4'd10: begin
          bus.iData <= ($urandom() & 32'hffff_fffe) | {31'd0, val_ok};
          val_total <= val_total + 1;
        end
        4'd6:    bus.iData <= s_res[127:96];
        4'd7:    bus.iData <= s_res[95:64];
        4'd8:    bus.iData <= s_res[63:32];
        4'd9:    bus.iData <= s_res[31:0];
        default: bus.iData <= $urandom();
      endcase
    end else begin
      bus.iData <= $urandom();
    end
  end

  logic [127:0] m_key = '0;
  logic [127:0] m_res = '0;

  function automatic acc_t mk(input bit w, input int a, input logic [31:0] d);
    acc_t x;
    x.we = w; x.addr = 4'(a); x.data = d; x.cyc = 0;
    return x;
  endfunction

  task automatic build_exp(input bit k, input logic [127:0] b, input int rzc, input int vzc, output bit e_err);
    exp_q.delete();
    e_err = 1'b0;
    for (int i = 0; i < ((rzc + 1 < PT) ? rzc + 1 : PT); i++) exp_q.push_back(mk(0, 15, 0));
    if (rzc >= PT) begin e_err = 1'b1; return; end
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, i, 32'(b >> (96 - 32 * i))));
    exp_q.push_back(mk(1, k ? 5 : 4, 0));
    if (k) return;
    for (int i = 0; i < ((vzc + 1 < PT) ? vzc + 1 : PT); i++) exp_q.push_back(mk(0, 10, 0));
    if (vzc >= PT) begin e_err = 1'b1; return; end
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 6 + i, 0));
  endtask

  // Called and returns at a negedge.
  task automatic do_cmd(input bit k, input logic [127:0] b, input int rzc, input int vzc,
                        input bit disturb, input bit rst_mid);
    bit e_err;
    bit got_done;
    int base;
    int li;
    build_exp(k, b, rzc, vzc, e_err);
    rz = rzc; vz = vzc; rdy_base = rdy_total; val_base = val_total;
    base = log_q.size();
    start = 1'b1; is_key = k; blk = b;
    @(negedge clk);
    start = 1'b0; is_key = 1'($urandom()); blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    got_done = 1'b0;
    for (int n = 0; n < 3000 && !got_done; n++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        check("busy", busy, 1);
        if (disturb && n == 4) begin start = 1'b1; blk = ~b; is_key = !k; end
        if (disturb && n == 5) start = 1'b0;
        if (rst_mid && !bus.oChipSelect_n && !bus.oRead_n && bus.oAddress == 4'd6) begin
          rstn = 1'b0;
          @(negedge clk);
          check("rst_cs", bus.oChipSelect_n, 1);
          check("rst_wr", bus.oWrite_n, 1);
          check("rst_rd", bus.oRead_n, 1);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_result", res, 0);
          rstn = 1'b1;
          m_res = '0;
          repeat (4) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
            check("rst_idle", busy, 0);
          end
          return;
        end
        @(negedge clk);
      end
    end
    if (!got_done) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("done_busy", busy, 0);
    check("error", err, e_err);
    if (!e_err && k)  m_key = b;
    if (!e_err && !k) m_res = tb_cipher(m_key, b);
    check("result", res, m_res);
    check("log_len", log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      check("log_we", log_q[base + i].we, exp_q[i].we);
      check("log_addr", log_q[base + i].addr, exp_q[i].addr);
      if (exp_q[i].we) check("log_data", log_q[base + i].data, exp_q[i].data);
    end
    if (!k && rzc < PT) begin
      li = rzc + 5;
      if (base + li + 1 < log_q.size())
        check("load_gap", (log_q[base + li + 1].cyc - log_q[base + li].cyc) > LG, 1);
    end
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  int b0;
  int n15, nwr, nres;

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cs", bus.oChipSelect_n, 1);
    check("reset_wr", bus.oWrite_n, 1);
    check("reset_rd", bus.oRead_n, 1);
    check("reset_addr", bus.oAddress, 0);
    check("reset_data", bus.oData, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_result", res, 0);
    rstn = 1'b1;
    @(negedge clk);

    b0 = log_q.size();
    do_cmd(1, FIPS_KEY, 0, 0, 0, 0);
    check("key_w0", log_q[b0 + 1].data, 32'h00010203);
    check("key_w1", log_q[b0 + 2].data, 32'h04050607);
    check("key_w2", log_q[b0 + 3].data, 32'h08090a0b);
    check("key_w3", log_q[b0 + 4].data, 32'h0c0d0e0f);
    check("key_load_addr", log_q[b0 + 5].addr, 5);
    nres = 0;
    for (int i = b0; i < log_q.size(); i++) if (log_q[i].addr >= 4'd6 && log_q[i].addr <= 4'd10) nres++;
    check("key_no_result_reads", nres, 0);

    do_cmd(0, FIPS_PT, 0, 2, 0, 0);
    check("fips_ct", res, FIPS_CT);

    b0 = log_q.size();
    do_cmd(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 5, 0, 0, 0);
    n15 = 0;
    for (int i = b0; i < log_q.size(); i++) if (!log_q[i].we && log_q[i].addr == 4'd15) n15++;
    check("ready_polls_6", n15, 6);

    b0 = log_q.size();
    do_cmd(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 50, 0, 0, 0);
    n15 = 0; nwr = 0;
    for (int i = b0; i < log_q.size(); i++) begin
      if (!log_q[i].we && log_q[i].addr == 4'd15) n15++;
      if (log_q[i].we) nwr++;
    end
    check("timeout_polls_8", n15, 8);
    check("timeout_no_writes", nwr, 0);
    check("timeout_err", err, 1);
    check("timeout_result_kept", res, FIPS_CT);

    do_cmd(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1, 1, 0);
    do_cmd(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 0, 0);

    do_cmd(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 0, 1);
    do_cmd(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, 0, 0);

    repeat (16) begin
      do_cmd(1'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()},
             int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 1'($urandom()), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
